// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the RV32I load/store stage and a
// byte-masked, word-addressed data memory.
//
// One request is accepted at a time. funct3 is decoded into access size and
// signedness. Memory is always addressed with word-aligned addresses and byte
// lane masks; an access whose bytes cross a word boundary is split into two
// memory accesses (the second word address wraps modulo DEPTH). Load data is
// reassembled, shifted down to bit 0 and sign/zero-extended.
//
// Request handshake: a request transfers on a rising edge where
// i_req_valid && o_req_ready. o_req_ready is high only while idle and not in
// reset. Request fields are latched at transfer. Exactly one o_rsp_valid
// pulse answers each accepted request; a request aborted by reset gets none.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_*               request (valid/ready, we, funct3, byte addr, wdata)
//   o_rsp_*               response pulse, extended load data, error flag
//   o_mem_*               word address, lane-shifted wdata, byte mask, wren
//   i_mem_rdata           memory read data, valid one cycle after o_mem_addr
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, accesses whose
// offset is not a multiple of their size are rejected with an error and no
// memory access instead of being split.

module lsu_mem_ctrl #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC1 = 3'd1,
    S_ACC2 = 3'd2,
    S_WAIT = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic                we_q, we_d;
  logic                split_q, split_d;
  logic [ADDR_W-1:0]   hi_addr_q, hi_addr_d;
  logic [3:0]          hi_mask_q, hi_mask_d;
  logic [31:0]         hi_wdata_q, hi_wdata_d;
  logic [31:0]         lo_q, lo_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_bmask_q, mem_bmask_d;
  logic                mem_wren_q, mem_wren_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;

  // Request decode and lane math
  logic [1:0]        req_off;
  logic [3:0]        size_mask;
  logic              legal;
  logic              misalign;
  logic [7:0]        mask8;
  logic [63:0]       data64;
  logic [ADDR_W-1:0] w0, w1;

  // Load reassembly
  logic [31:0] hi_word, lo_word, load_word, load_ext;

  always_comb begin
    req_off   = i_req_addr[1:0];
    size_mask = 4'b0000;
    legal     = 1'b0;
    unique case (i_req_funct3)
      3'b000:  begin size_mask = 4'b0001; legal = 1'b1;       end
      3'b001:  begin size_mask = 4'b0011; legal = 1'b1;       end
      3'b010:  begin size_mask = 4'b1111; legal = 1'b1;       end
      3'b100:  begin size_mask = 4'b0001; legal = !i_req_we;  end
      3'b101:  begin size_mask = 4'b0011; legal = !i_req_we;  end
      default: begin size_mask = 4'b0000; legal = 1'b0;       end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (i_req_funct3[1:0] == 2'b01 && req_off[0]) ||
               (i_req_funct3[1:0] == 2'b10 && req_off != 2'b00);
`else
    misalign = 1'b0;
`endif
    mask8  = {4'b0000, size_mask} << req_off;
    data64 = {32'd0, i_req_wdata} << {req_off, 3'b000};
    w0     = {i_req_addr[ADDR_W-1:2], 2'b00};
    w1     = w0 + ADDR_W'(4);  // natural wrap modulo DEPTH
  end

  always_comb begin
    // Unsplit loads see their only word in WAIT; split loads see the high
    // word in WAIT and the low word was captured in ACC2.
    hi_word   = split_q ? i_mem_rdata : 32'd0;
    lo_word   = split_q ? lo_q : i_mem_rdata;
    load_word = 32'({hi_word, lo_word} >> {off_q, 3'b000});
    unique case (f3_q)
      3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_ext = {24'd0, load_word[7:0]};
      3'b101:  load_ext = {16'd0, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    f3_d        = f3_q;
    we_d        = we_q;
    split_d     = split_q;
    hi_addr_d   = hi_addr_q;
    hi_mask_d   = hi_mask_q;
    hi_wdata_d  = hi_wdata_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = 4'b0000;
    mem_wren_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          off_d      = req_off;
          f3_d       = i_req_funct3;
          we_d       = i_req_we;
          split_d    = |mask8[7:4];
          hi_addr_d  = w1;
          hi_mask_d  = mask8[7:4];
          hi_wdata_d = data64[63:32];
          if (!legal || misalign) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d     = S_ACC1;
            mem_addr_d  = w0;
            mem_wdata_d = i_req_we ? data64[31:0] : 32'd0;
            mem_bmask_d = i_req_we ? mask8[3:0] : 4'b0000;
            mem_wren_d  = i_req_we;
          end
        end
      end
      S_ACC1: begin
        if (split_q) begin
          state_d     = S_ACC2;
          mem_addr_d  = hi_addr_q;
          mem_wdata_d = we_q ? hi_wdata_q : 32'd0;
          mem_bmask_d = we_q ? hi_mask_q : 4'b0000;
          mem_wren_d  = we_q;
        end else if (we_q) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACC2: begin
        lo_d = i_mem_rdata;
        if (we_q) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d     = S_RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_ext;
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      hi_addr_q   <= '0;
      hi_mask_q   <= 4'b0000;
      hi_wdata_q  <= 32'd0;
      lo_q        <= 32'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_bmask_q <= 4'b0000;
      mem_wren_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      split_q     <= split_d;
      hi_addr_q   <= hi_addr_d;
      hi_mask_q   <= hi_mask_d;
      hi_wdata_q  <= hi_wdata_d;
      lo_q        <= lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      mem_wren_q  <= mem_wren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Reset gates the strobe combinationally so a reset cycle never commits.
  assign o_mem_wren  = mem_wren_q && !i_reset;
  assign o_req_ready = (state_q == S_IDLE) && !i_reset;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rsp_rdata_q;

endmodule
